// File: rtl/lpc_host.sv
// lpc_host: LPC bus initiator for single-byte I/O and TPM-locality cycles.
// Converts one request from the internal request/response port into one LPC
// cycle on LFRAME#/LAD[3:0], waits for the peripheral SYNC, and returns one
// response. The LAD tri-state buffer lives in the parent, so LAD is split.
//
// Ports:
//   clk_i, rst_i          LPC clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake (accepted on valid & ready)
//   req_write_i           1 = write, 0 = read
//   req_tpm_i             1 = TPM cycle (START 0101), 0 = I/O (START 0000)
//   req_addr_i[15:0]      cycle address
//   req_wdata_i[7:0]      write data
//   rsp_valid_o           one-clock completion pulse
//   rsp_rdata_o[7:0]      read data, held until the next response
//   rsp_status_o[1:0]     00 OK, 01 SYNC error, 10 timeout/abort
//   lframe_o              LFRAME#, active-low
//   lad_o, lad_oe_o       LAD drive value and enable
//   lad_i                 sampled LAD value
module lpc_host #(
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_tpm_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic [1:0]  rsp_status_o,
  output logic        lframe_o,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  input  logic [3:0]  lad_i
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START   = 4'd1,
    S_CYCTYPE = 4'd2,
    S_ADDR    = 4'd3,
    S_WDATA   = 4'd4,
    S_HTAR1   = 4'd5,
    S_HTAR2   = 4'd6,
    S_SYNC    = 4'd7,
    S_RDATA   = 4'd8,
    S_PTAR1   = 4'd9,
    S_PTAR2   = 4'd10,
    S_RESP    = 4'd11,
    S_ABORT   = 4'd12
  } state_t;

  localparam logic [3:0] NIB_IDLE  = 4'b1111;
  localparam logic [3:0] SYNC_OK   = 4'b0000;
  localparam logic [3:0] SYNC_ERR  = 4'b1010;
  // Last wait-counter value before the cycle is abandoned.
  localparam logic [7:0] TMO_LAST  = 8'(SYNC_TIMEOUT - 1);

  // Address nibble for ADDR clock idx, most significant nibble first.
  function automatic logic [3:0] addr_nib(input logic [15:0] addr, input logic [1:0] idx);
    case (idx)
      2'd0:    addr_nib = addr[15:12];
      2'd1:    addr_nib = addr[11:8];
      2'd2:    addr_nib = addr[7:4];
      2'd3:    addr_nib = addr[3:0];
      default: addr_nib = NIB_IDLE;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;          // ADDR/WDATA/RDATA/ABORT index, SYNC wait count
  logic        write_q, write_d;
  logic        tpm_q, tpm_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;      // capture register; copied out at RESP
  logic [1:0]  status_q, status_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic        lframe_q, lframe_d;
  logic [3:0]  lad_q, lad_d;
  logic        lad_oe_q, lad_oe_d;

  // Next-state and next-output computation; outputs are registered below.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    tpm_d        = tpm_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    status_d     = status_q;
    ready_d      = ready_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;
    lframe_d     = lframe_q;
    lad_d        = lad_q;
    lad_oe_d     = lad_oe_q;
    case (state_q)
      // RESP behaves as IDLE on the bus, so a held request is taken on its edge.
      S_IDLE, S_RESP: begin
        if (req_valid_i && ready_q) begin
          state_d  = S_START;
          write_d  = req_write_i;
          tpm_d    = req_tpm_i;
          addr_d   = req_addr_i;
          wdata_d  = req_wdata_i;
          rdata_d  = 8'h00;
          status_d = 2'b00;
          cnt_d    = 8'd0;
          ready_d  = 1'b0;
          lframe_d = 1'b0;
          lad_oe_d = 1'b1;
          lad_d    = req_tpm_i ? 4'b0101 : 4'b0000;
        end else begin
          state_d  = S_IDLE;
          ready_d  = 1'b1;
          lframe_d = 1'b1;
          lad_oe_d = 1'b0;
          lad_d    = NIB_IDLE;
        end
      end
      S_START: begin
        state_d  = S_CYCTYPE;
        lframe_d = 1'b1;
        lad_d    = write_q ? 4'b0010 : 4'b0000;
      end
      S_CYCTYPE: begin
        state_d = S_ADDR;
        cnt_d   = 8'd0;
        lad_d   = addr_nib(addr_q, 2'd0);
      end
      S_ADDR: begin
        if (cnt_q[1:0] == 2'd3) begin
          cnt_d = 8'd0;
          if (write_q) begin
            state_d = S_WDATA;
            lad_d   = wdata_q[3:0];
          end else begin
            state_d = S_HTAR1;
            lad_d   = NIB_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          lad_d = addr_nib(addr_q, cnt_q[1:0] + 2'd1);
        end
      end
      S_WDATA: begin
        if (cnt_q[0]) begin
          state_d = S_HTAR1;
          lad_d   = NIB_IDLE;
        end else begin
          cnt_d = 8'd1;
          lad_d = wdata_q[7:4];
        end
      end
      S_HTAR1: begin
        // Release the bus before the peripheral may drive it.
        state_d  = S_HTAR2;
        lad_oe_d = 1'b0;
        lad_d    = NIB_IDLE;
        cnt_d    = 8'd0;
      end
      S_HTAR2: begin
        state_d = S_SYNC;
      end
      S_SYNC: begin
        if ((lad_i == SYNC_OK) || (lad_i == SYNC_ERR)) begin
          status_d = (lad_i == SYNC_ERR) ? 2'b01 : 2'b00;
          cnt_d    = 8'd0;
          state_d  = write_q ? S_PTAR1 : S_RDATA;
        end else if (cnt_q == TMO_LAST) begin
          // Every non-terminating nibble (including long wait) counts here.
          state_d  = S_ABORT;
          cnt_d    = 8'd0;
          lframe_d = 1'b0;
          lad_oe_d = 1'b1;
          lad_d    = NIB_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RDATA: begin
        if (cnt_q[0]) begin
          rdata_d[7:4] = lad_i;
          state_d      = S_PTAR1;
        end else begin
          rdata_d[3:0] = lad_i;
          cnt_d        = 8'd1;
        end
      end
      S_PTAR1: begin
        state_d = S_PTAR2;
      end
      S_PTAR2: begin
        state_d      = S_RESP;
        ready_d      = 1'b1;
        rsp_valid_d  = 1'b1;
        rsp_rdata_d  = rdata_q;
        rsp_status_d = status_q;
      end
      S_ABORT: begin
        if (cnt_q[1:0] == 2'd3) begin
          state_d      = S_RESP;
          lframe_d     = 1'b1;
          lad_oe_d     = 1'b0;
          lad_d        = NIB_IDLE;
          ready_d      = 1'b1;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = rdata_q;
          rsp_status_d = 2'b10;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ready_d  = 1'b0;
        lframe_d = 1'b1;
        lad_oe_d = 1'b0;
        lad_d    = NIB_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases the bus without a response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      write_q      <= 1'b0;
      tpm_q        <= 1'b0;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      rdata_q      <= 8'h00;
      status_q     <= 2'b00;
      ready_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      rsp_status_q <= 2'b00;
      lframe_q     <= 1'b1;
      lad_q        <= NIB_IDLE;
      lad_oe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      tpm_q        <= tpm_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      status_q     <= status_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
      lframe_q     <= lframe_d;
      lad_q        <= lad_d;
      lad_oe_q     <= lad_oe_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign rsp_status_o = rsp_status_q;
  assign lframe_o     = lframe_q;
  assign lad_o        = lad_q;
  assign lad_oe_o     = lad_oe_q;

endmodule

// File: tb/tb_lpc_host.sv
// tb_lpc_host: directed, table-driven bench for lpc_host. A small peripheral
// emulation drives lad_i clock by clock from each vector; the expected bus
// nibbles come from the LPC frame layout, latencies and results are hand-set.
module tb_lpc_host;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic        req_tpm_i;
  logic [15:0] req_addr_i;
  logic [7:0]  req_wdata_i;
  logic        rsp_valid_o;
  logic [7:0]  rsp_rdata_o;
  logic [1:0]  rsp_status_o;
  logic        lframe_o;
  logic [3:0]  lad_o;
  logic        lad_oe_o;
  logic [3:0]  lad_i;

  always #5 clk_i = ~clk_i;

  lpc_host #(.SYNC_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_tpm_i(req_tpm_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_status_o(rsp_status_o),
    .lframe_o(lframe_o), .lad_o(lad_o), .lad_oe_o(lad_oe_o), .lad_i(lad_i)
  );

  typedef struct {
    logic        write;
    logic        tpm;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          waits;      // wait-state nibbles before SYNC
    logic [3:0]  wait_nib;
    logic [3:0]  sync_nib;
    logic        tmo;        // peripheral never answers
    logic [7:0]  pdata;      // data returned by the peripheral on reads
    logic [1:0]  exp_status;
    int          exp_rsp_clk; // clock (after acceptance edge) with rsp_valid
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected host bus in clock k: {lframe, oe, lad_care, lad}.
  function automatic logic [6:0] exp_bus(input vec_t v, input int k);
    int          drv_end;
    logic [15:0] a;
    drv_end = v.write ? 9 : 7;
    a = v.addr >> (4 * (6 - k));
    if (k == 1)                         exp_bus = {3'b011, v.tpm ? 4'h5 : 4'h0};
    else if (k == 2)                    exp_bus = {3'b111, v.write ? 4'h2 : 4'h0};
    else if (k >= 3 && k <= 6)          exp_bus = {3'b111, a[3:0]};
    else if (v.write && k == 7)         exp_bus = {3'b111, v.wdata[3:0]};
    else if (v.write && k == 8)         exp_bus = {3'b111, v.wdata[7:4]};
    else if (k == drv_end)              exp_bus = {3'b111, 4'hF};
    else if (v.tmo && k >= v.exp_rsp_clk - 4 && k < v.exp_rsp_clk)
                                        exp_bus = {3'b011, 4'hF};
    else                                exp_bus = {3'b100, 4'hF};
  endfunction

  // Peripheral drive in clock k: {driving, nibble}.
  function automatic logic [4:0] periph(input vec_t v, input int k);
    int s;
    s = k - (v.write ? 11 : 9);
    if (v.tmo || s < 0)                      periph = {1'b0, 4'hF};
    else if (s < v.waits)                    periph = {1'b1, v.wait_nib};
    else if (s == v.waits)                   periph = {1'b1, v.sync_nib};
    else if (!v.write && s == v.waits + 1)   periph = {1'b1, v.pdata[3:0]};
    else if (!v.write && s == v.waits + 2)   periph = {1'b1, v.pdata[7:4]};
    else                                     periph = {1'b0, 4'hF};
  endfunction

  task automatic set_req(input vec_t v);
    req_write_i = v.write;
    req_tpm_i   = v.tpm;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
  endtask

  // Run one cycle; ends at the negedge of the RESP clock.
  task automatic run_vec(input vec_t v, input bit pre, input bit hold, input vec_t nxt, input string tag);
    logic [6:0] eb;
    logic [4:0] pd;
    logic [6:0] got;
    int bad_clk = 0, overlap = 0, valid_clk = 0, nvalid = 0;
    logic ready_at_resp = 1'b0;
    if (!pre) begin
      @(negedge clk_i);
      set_req(v);
      req_valid_i = 1'b1;
      check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
      @(posedge clk_i);
    end
    for (int k = 1; k <= v.exp_rsp_clk; k++) begin
      @(negedge clk_i);
      if (k == 1) begin
        if (hold) set_req(nxt);
        else req_valid_i = 1'b0;
      end
      eb = exp_bus(v, k);
      if (bad_clk == 0 && (lframe_o !== eb[6] || lad_oe_o !== eb[5] || (eb[4] && lad_o !== eb[3:0]))) begin
        bad_clk = k;
        got = {lframe_o, lad_oe_o, eb[4], lad_o};
      end
      if (rsp_valid_o === 1'b1) begin
        nvalid++;
        valid_clk = k;
      end
      if (k == v.exp_rsp_clk) ready_at_resp = req_ready_o;
      pd = periph(v, k);
      if (pd[4] && lad_oe_o !== 1'b0) overlap++;
      lad_i = pd[3:0];
    end
    checks++;
    if (bad_clk != 0) begin
      errors++;
      $display("FAIL %s_bus: clock %0d got lframe,oe,care,lad=%b want %b", tag, bad_clk, got, exp_bus(v, bad_clk));
    end
    check({tag, "_rsp_clk"}, 32'(valid_clk), 32'(v.exp_rsp_clk));
    check({tag, "_rsp_cnt"}, 32'(nvalid), 32'd1);
    check({tag, "_status"}, 32'(rsp_status_o), 32'(v.exp_status));
    if (!v.write && !v.tmo) check({tag, "_rdata"}, 32'(rsp_rdata_o), 32'(v.pdata));
    check({tag, "_ready_resp"}, 32'(ready_at_resp), 32'd1);
    check({tag, "_oe_overlap"}, 32'(overlap), 32'd0);
  endtask

  vec_t vecs[7];
  vec_t va, vb;
  int   pulses, lf_low;

  initial begin
    //        wr    tpm   addr      wdata  wt nib    sync   tmo   pdata  st     rsp
    vecs[0] = '{1'b1, 1'b0, 16'h0080, 8'h5A, 0, 4'h5, 4'h0, 1'b0, 8'h00, 2'b00, 14};
    vecs[1] = '{1'b0, 1'b1, 16'h0F00, 8'h00, 3, 4'h5, 4'h0, 1'b0, 8'hC3, 2'b00, 17};
    vecs[2] = '{1'b0, 1'b0, 16'h0060, 8'h00, 0, 4'h5, 4'hA, 1'b0, 8'h11, 2'b01, 14};
    vecs[3] = '{1'b0, 1'b0, 16'h1234, 8'h00, 0, 4'h5, 4'hF, 1'b1, 8'h00, 2'b10, 29};
    vecs[4] = '{1'b1, 1'b1, 16'hABCD, 8'h96, 2, 4'h6, 4'h0, 1'b0, 8'h00, 2'b00, 16};
    vecs[5] = '{1'b1, 1'b0, 16'h0001, 8'hE7, 0, 4'h5, 4'hF, 1'b1, 8'h00, 2'b10, 31};
    vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 1, 4'h5, 4'hA, 1'b0, 8'h7E, 2'b01, 15};
    va      = '{1'b1, 1'b0, 16'h0300, 8'h12, 0, 4'h5, 4'h0, 1'b0, 8'h00, 2'b00, 14};
    vb      = '{1'b1, 1'b1, 16'h0301, 8'h34, 0, 4'h5, 4'h0, 1'b0, 8'h00, 2'b00, 14};

    rst_i = 1'b1;
    req_valid_i = 1'b0;
    set_req(va);
    lad_i = 4'hF;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_lframe", 32'(lframe_o), 32'd1);
    check("rst_oe", 32'(lad_oe_o), 32'd0);
    check("rst_lad", 32'(lad_o), 32'hF);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rdata", 32'(rsp_rdata_o), 32'd0);
    check("rst_status", 32'(rsp_status_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_release_ready", 32'(req_ready_o), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], 1'b0, 1'b0, va, $sformatf("vec%0d", i));
      @(negedge clk_i);
    end

    // Reset during the ADDR phase of a write.
    pulses = 0;
    @(negedge clk_i);
    set_req(vecs[0]);
    req_valid_i = 1'b1;
    @(posedge clk_i);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      if (rsp_valid_o === 1'b1) pulses++;
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rstmid_lframe", 32'(lframe_o), 32'd1);
    check("rstmid_oe", 32'(lad_oe_o), 32'd0);
    if (rsp_valid_o === 1'b1) pulses++;
    @(negedge clk_i);
    if (rsp_valid_o === 1'b1) pulses++;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_ready", 32'(req_ready_o), 32'd1);
    lf_low = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid_o === 1'b1) pulses++;
      if (lframe_o !== 1'b1) lf_low++;
      @(negedge clk_i);
    end
    check("rstmid_no_rsp", 32'(pulses), 32'd0);
    check("rstmid_no_abort", 32'(lf_low), 32'd0);

    // Back-to-back writes with req_valid held through the first RESP.
    run_vec(va, 1'b0, 1'b1, vb, "b2b_a");
    check("b2b_resp_lframe", 32'(lframe_o), 32'd1);
    check("b2b_valid_held", 32'(req_valid_i), 32'd1);
    run_vec(vb, 1'b1, 1'b0, va, "b2b_b");
    @(negedge clk_i);
    check("b2b_idle_after", 32'(lframe_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
